// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle control FSM sequencing fetch, decode, execute, memory and writeback
// Optional byte load/store support (lb/sb, ByteOp) is enabled by defining CTRL_BYTE_OPS_EN.
module multicycle_control (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Instr,
   input  logic        Zero,
   output logic        PC_LdEn,
   output logic        PC_Sel,
   output logic        IR_LdEn,
   output logic        RF_WrEn,
   output logic        RF_WrData_sel,
   output logic        RF_B_sel,
   output logic        ALU_Bin_sel,
   output logic [3:0]  ALU_func,
   output logic [1:0]  ImmExt,
   output logic        Mem_WrEn,
   output logic        ByteOp
);

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, EXEC_BR,
      MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM
   } state_t;

   localparam logic [5:0] OP_R    = 6'b100000;
   localparam logic [5:0] OP_LI   = 6'b111000;
   localparam logic [5:0] OP_LUI  = 6'b111001;
   localparam logic [5:0] OP_ADDI = 6'b110000;
   localparam logic [5:0] OP_ANDI = 6'b110010;
   localparam logic [5:0] OP_ORI  = 6'b110011;
   localparam logic [5:0] OP_B    = 6'b111111;
   localparam logic [5:0] OP_BEQ  = 6'b000000;
   localparam logic [5:0] OP_BNE  = 6'b000001;
   localparam logic [5:0] OP_LW   = 6'b001111;
   localparam logic [5:0] OP_SW   = 6'b011111;
`ifdef CTRL_BYTE_OPS_EN
   localparam logic [5:0] OP_LB   = 6'b000011;
   localparam logic [5:0] OP_SB   = 6'b000111;
`endif

   state_t      state_q, state_d;
   logic [5:0]  opcode_q, opcode_d;
   logic [3:0]  func_q, func_d;
   logic        pc_ld_en_q, pc_ld_en_d;
   logic        ir_ld_en_q, ir_ld_en_d;
   logic        rf_wr_en_q, rf_wr_en_d;
   logic        rf_wr_data_sel_q, rf_wr_data_sel_d;
   logic        rf_b_sel_q, rf_b_sel_d;
   logic        alu_bin_sel_q, alu_bin_sel_d;
   logic [3:0]  alu_func_q, alu_func_d;
   logic [1:0]  imm_ext_q, imm_ext_d;
   logic        mem_wr_en_q, mem_wr_en_d;

   logic [5:0]  op;
   logic [3:0]  fn;
   logic        is_r, is_imm, is_br, is_lb, is_sb, is_load, is_store, is_undef;
   logic        unused_instr;

   assign unused_instr = ^Instr[25:4];

   // Outputs for DECODE are registered during FETCH, so the live word is decoded
   // until the opcode register is loaded at the end of DECODE.
   always_comb begin
      op       = opcode_q;
      fn       = func_q;
      if (state_q == FETCH || state_q == DECODE) begin
         op = Instr[31:26];
         fn = Instr[3:0];
      end
      opcode_d = (state_q == DECODE) ? Instr[31:26] : opcode_q;
      func_d   = (state_q == DECODE) ? Instr[3:0]   : func_q;
`ifdef CTRL_BYTE_OPS_EN
      is_lb    = (op == OP_LB);
      is_sb    = (op == OP_SB);
`else
      is_lb    = 1'b0;
      is_sb    = 1'b0;
`endif
      is_r     = (op == OP_R);
      is_imm   = (op == OP_LI) || (op == OP_LUI) || (op == OP_ADDI) ||
                 (op == OP_ANDI) || (op == OP_ORI);
      is_br    = (op == OP_B) || (op == OP_BEQ) || (op == OP_BNE);
      is_load  = (op == OP_LW) || is_lb;
      is_store = (op == OP_SW) || is_sb;
      is_undef = !(is_r || is_imm || is_br || is_load || is_store);
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = DECODE;
         DECODE: begin
            if (is_r)                     state_d = EXEC_R;
            else if (is_imm)              state_d = EXEC_I;
            else if (is_br)               state_d = EXEC_BR;
            else if (is_load || is_store) state_d = MEM_ADDR;
            else                          state_d = FETCH;
         end
         EXEC_R:   state_d = WB_ALU;
         EXEC_I:   state_d = WB_ALU;
         MEM_ADDR: state_d = is_load ? MEM_RD : MEM_WR;
         MEM_RD:   state_d = WB_MEM;
         default:  state_d = FETCH;
      endcase
   end

   always_comb begin
      pc_ld_en_d       = 1'b0;
      ir_ld_en_d       = 1'b0;
      rf_wr_en_d       = 1'b0;
      rf_wr_data_sel_d = 1'b0;
      rf_b_sel_d       = 1'b0;
      alu_bin_sel_d    = 1'b0;
      alu_func_d       = 4'b0000;
      imm_ext_d        = 2'b00;
      mem_wr_en_d      = 1'b0;
      case (state_d)
         DECODE: begin
            ir_ld_en_d = 1'b1;
            rf_b_sel_d = (op == OP_BEQ) || (op == OP_BNE) || is_store;
            pc_ld_en_d = is_undef;
         end
         EXEC_R:   alu_func_d = fn;
         EXEC_I: begin
            alu_bin_sel_d = 1'b1;
            if (op == OP_LUI)       imm_ext_d = 2'b10;
            else if (op == OP_ANDI) begin alu_func_d = 4'b0010; imm_ext_d = 2'b01; end
            else if (op == OP_ORI)  begin alu_func_d = 4'b0011; imm_ext_d = 2'b01; end
         end
         EXEC_BR: begin
            alu_func_d = 4'b0001;
            rf_b_sel_d = 1'b1;
            imm_ext_d  = 2'b11;
            pc_ld_en_d = 1'b1;
         end
         MEM_ADDR: alu_bin_sel_d = 1'b1;
         MEM_WR: begin
            mem_wr_en_d = 1'b1;
            pc_ld_en_d  = 1'b1;
         end
         WB_ALU: begin
            rf_wr_en_d    = 1'b1;
            pc_ld_en_d    = 1'b1;
            alu_bin_sel_d = alu_bin_sel_q;
            alu_func_d    = alu_func_q;
            imm_ext_d     = imm_ext_q;
         end
         WB_MEM: begin
            rf_wr_en_d       = 1'b1;
            rf_wr_data_sel_d = 1'b1;
            pc_ld_en_d       = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q          <= FETCH;
         opcode_q         <= 6'b0;
         func_q           <= 4'b0;
         pc_ld_en_q       <= 1'b0;
         ir_ld_en_q       <= 1'b0;
         rf_wr_en_q       <= 1'b0;
         rf_wr_data_sel_q <= 1'b0;
         rf_b_sel_q       <= 1'b0;
         alu_bin_sel_q    <= 1'b0;
         alu_func_q       <= 4'b0;
         imm_ext_q        <= 2'b0;
         mem_wr_en_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         opcode_q         <= opcode_d;
         func_q           <= func_d;
         pc_ld_en_q       <= pc_ld_en_d;
         ir_ld_en_q       <= ir_ld_en_d;
         rf_wr_en_q       <= rf_wr_en_d;
         rf_wr_data_sel_q <= rf_wr_data_sel_d;
         rf_b_sel_q       <= rf_b_sel_d;
         alu_bin_sel_q    <= alu_bin_sel_d;
         alu_func_q       <= alu_func_d;
         imm_ext_q        <= imm_ext_d;
         mem_wr_en_q      <= mem_wr_en_d;
      end
   end

`ifdef CTRL_BYTE_OPS_EN
   logic byte_op_q, byte_op_d;

   always_comb begin
      byte_op_d = ((state_d == MEM_RD) && is_lb) || ((state_d == MEM_WR) && is_sb);
   end

   always_ff @(posedge Clk) begin
      if (Reset) byte_op_q <= 1'b0;
      else       byte_op_q <= byte_op_d;
   end

   assign ByteOp = byte_op_q;
`else
   assign ByteOp = 1'b0;
`endif

   // Branch resolution must see Zero in the same cycle the ALU compares.
   assign PC_Sel = (state_q == EXEC_BR) &&
                   ((opcode_q == OP_B) ||
                    ((opcode_q == OP_BEQ) && Zero) ||
                    ((opcode_q == OP_BNE) && !Zero));

   assign PC_LdEn       = pc_ld_en_q;
   assign IR_LdEn       = ir_ld_en_q;
   assign RF_WrEn       = rf_wr_en_q;
   assign RF_WrData_sel = rf_wr_data_sel_q;
   assign RF_B_sel      = rf_b_sel_q;
   assign ALU_Bin_sel   = alu_bin_sel_q;
   assign ALU_func      = alu_func_q;
   assign ImmExt        = imm_ext_q;
   assign Mem_WrEn      = mem_wr_en_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with directed instruction vectors
module tb_multicycle_control;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] Instr;
   logic        Zero;
   logic        PC_LdEn, PC_Sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
   logic [3:0]  ALU_func;
   logic [1:0]  ImmExt;
   logic        Mem_WrEn, ByteOp;

   int errors = 0;
   int checks = 0;
   logic [14:0] exp_q[$];
   string       name_q[$];

   multicycle_control dut (
      .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
      .PC_LdEn(PC_LdEn), .PC_Sel(PC_Sel), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
      .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
      .ALU_func(ALU_func), .ImmExt(ImmExt), .Mem_WrEn(Mem_WrEn), .ByteOp(ByteOp)
   );

   always #5 Clk = ~Clk;

   // Packed order: PC_LdEn PC_Sel IR_LdEn RF_WrEn RF_WrData_sel RF_B_sel ALU_Bin_sel ALU_func ImmExt Mem_WrEn ByteOp
   function automatic logic [14:0] v(input bit pl, input bit ps, input bit ir, input bit rw,
                                     input bit ws, input bit rb, input bit bs,
                                     input logic [3:0] fn, input logic [1:0] im,
                                     input bit mw, input bit bo);
      return {pl, ps, ir, rw, ws, rb, bs, fn, im, mw, bo};
   endfunction

   localparam logic [31:0] I_ADD  = 32'h8000_0000;
   localparam logic [31:0] I_SUB5 = 32'h8000_0005;
   localparam logic [31:0] I_ANDI = 32'hC800_00FF;
   localparam logic [31:0] I_ORI  = 32'hCC00_0001;
   localparam logic [31:0] I_LUI  = 32'hE400_1234;
   localparam logic [31:0] I_LI   = 32'hE000_0007;
   localparam logic [31:0] I_B    = 32'hFC00_0010;
   localparam logic [31:0] I_BEQ  = 32'h0000_0010;
   localparam logic [31:0] I_BNE  = 32'h0400_0010;
   localparam logic [31:0] I_LW   = 32'h3C00_0004;
   localparam logic [31:0] I_SW   = 32'h7C00_0004;
   localparam logic [31:0] I_SB   = 32'h1C00_0004;
   localparam logic [31:0] I_UND  = 32'hA800_0000;

   task automatic cyc(input logic rst, input logic [31:0] ins, input logic z,
                      input logic [14:0] e, input string nm);
      Reset = rst;
      Instr = ins;
      Zero  = z;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         logic [14:0] e, got;
         string nm;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {PC_LdEn, PC_Sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                ALU_func, ImmExt, Mem_WrEn, ByteOp};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, got, e);
         end
      end
   end

   initial begin
      logic [14:0] z0, dec0, dec1, br_t, br_n;
      z0   = v(0,0,0,0,0,0,0,4'b0000,2'b00,0,0);
      dec0 = v(0,0,1,0,0,0,0,4'b0000,2'b00,0,0);
      dec1 = v(0,0,1,0,0,1,0,4'b0000,2'b00,0,0);
      br_t = v(1,1,0,0,0,1,0,4'b0001,2'b11,0,0);
      br_n = v(1,0,0,0,0,1,0,4'b0001,2'b11,0,0);

      Reset = 1'b1; Instr = I_ADD; Zero = 1'b0;
      @(posedge Clk); #1;
      cyc(1, I_ADD, 0, z0, "reset_hold1");
      cyc(1, I_ADD, 0, z0, "reset_hold2");

      cyc(0, I_ADD, 0, z0,   "add_fetch");
      cyc(0, I_ADD, 0, dec0, "add_decode");
      cyc(0, I_ADD, 0, z0,   "add_exec");
      cyc(0, I_ADD, 0, v(1,0,0,1,0,0,0,4'b0000,2'b00,0,0), "add_wb");

      cyc(0, I_SUB5, 0, z0,   "r5_fetch");
      cyc(0, I_SUB5, 0, dec0, "r5_decode");
      cyc(0, I_SUB5, 0, v(0,0,0,0,0,0,0,4'b0101,2'b00,0,0), "r5_exec");
      cyc(0, I_SUB5, 0, v(1,0,0,1,0,0,0,4'b0101,2'b00,0,0), "r5_wb");

      // Instr changes after DECODE must not disturb the andi sequence
      cyc(0, I_ANDI, 0, z0,   "andi_fetch");
      cyc(0, I_ANDI, 0, dec0, "andi_decode");
      cyc(0, I_LW,   0, v(0,0,0,0,0,0,1,4'b0010,2'b01,0,0), "andi_exec");
      cyc(0, I_SW,   0, v(1,0,0,1,0,0,1,4'b0010,2'b01,0,0), "andi_wb");

      cyc(0, I_ORI, 0, z0,   "ori_fetch");
      cyc(0, I_ORI, 0, dec0, "ori_decode");
      cyc(0, I_ORI, 0, v(0,0,0,0,0,0,1,4'b0011,2'b01,0,0), "ori_exec");
      cyc(0, I_ORI, 0, v(1,0,0,1,0,0,1,4'b0011,2'b01,0,0), "ori_wb");

      cyc(0, I_LUI, 0, z0,   "lui_fetch");
      cyc(0, I_LUI, 0, dec0, "lui_decode");
      cyc(0, I_LUI, 0, v(0,0,0,0,0,0,1,4'b0000,2'b10,0,0), "lui_exec");
      cyc(0, I_LUI, 0, v(1,0,0,1,0,0,1,4'b0000,2'b10,0,0), "lui_wb");

      cyc(0, I_LI, 0, z0,   "li_fetch");
      cyc(0, I_LI, 0, dec0, "li_decode");
      cyc(0, I_LI, 0, v(0,0,0,0,0,0,1,4'b0000,2'b00,0,0), "li_exec");
      cyc(0, I_LI, 0, v(1,0,0,1,0,0,1,4'b0000,2'b00,0,0), "li_wb");

      cyc(0, I_BEQ, 0, z0,   "beq1_fetch");
      cyc(0, I_BEQ, 0, dec1, "beq1_decode");
      cyc(0, I_BEQ, 1, br_t, "beq_taken");
      cyc(0, I_BEQ, 0, z0,   "beq0_fetch");
      cyc(0, I_BEQ, 1, dec1, "beq0_decode");
      cyc(0, I_BEQ, 0, br_n, "beq_not_taken");
      cyc(0, I_BNE, 0, z0,   "bne_fetch");
      cyc(0, I_BNE, 0, dec1, "bne_decode");
      cyc(0, I_BNE, 0, br_t, "bne_taken");
      cyc(0, I_BNE, 0, z0,   "bne1_fetch");
      cyc(0, I_BNE, 0, dec1, "bne1_decode");
      cyc(0, I_BNE, 1, br_n, "bne_not_taken");
      cyc(0, I_B,   1, z0,   "b_fetch");
      cyc(0, I_B,   1, dec0, "b_decode");
      cyc(0, I_B,   1, br_t, "b_taken");

      cyc(0, I_LW, 0, z0,   "lw_fetch");
      cyc(0, I_LW, 0, dec0, "lw_decode");
      cyc(0, I_LW, 0, v(0,0,0,0,0,0,1,4'b0000,2'b00,0,0), "lw_addr");
      cyc(0, I_LW, 0, z0,   "lw_rd");
      cyc(0, I_LW, 0, v(1,0,0,1,1,0,0,4'b0000,2'b00,0,0), "lw_wb");

      cyc(0, I_SW, 0, z0,   "sw_fetch");
      cyc(0, I_SW, 0, dec1, "sw_decode");
      cyc(0, I_SW, 0, v(0,0,0,0,0,0,1,4'b0000,2'b00,0,0), "sw_addr");
      cyc(0, I_SW, 0, v(1,0,0,0,0,0,0,4'b0000,2'b00,1,0), "sw_wr");

      cyc(0, I_SB, 0, z0, "sb_fetch");
`ifdef CTRL_BYTE_OPS_EN
      cyc(0, I_SB, 0, dec1, "sb_decode");
      cyc(0, I_SB, 0, v(0,0,0,0,0,0,1,4'b0000,2'b00,0,0), "sb_addr");
      cyc(0, I_SB, 0, v(1,0,0,0,0,0,0,4'b0000,2'b00,1,1), "sb_wr");
`else
      cyc(0, I_SB, 0, v(1,0,1,0,0,0,0,4'b0000,2'b00,0,0), "sb_nop");
`endif

      cyc(0, I_UND, 0, z0, "und_fetch");
      cyc(0, I_UND, 0, v(1,0,1,0,0,0,0,4'b0000,2'b00,0,0), "und_nop");

      cyc(0, I_LW, 0, z0,   "lwr_fetch");
      cyc(0, I_LW, 0, dec0, "lwr_decode");
      cyc(0, I_LW, 0, v(0,0,0,0,0,0,1,4'b0000,2'b00,0,0), "lwr_addr");
      cyc(1, I_LW, 0, z0,   "lwr_rd_reset");
      cyc(0, I_ADD, 0, z0,  "post_reset_fetch");
      cyc(0, I_ADD, 0, dec0, "post_reset_decode");
      cyc(0, I_ADD, 0, z0,  "post_reset_exec");
      cyc(0, I_ADD, 0, v(1,0,0,1,0,0,0,4'b0000,2'b00,0,0), "post_reset_wb");

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge Clk);
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM for the processor datapath. It consumes the 32-bit instruction word produced by the instruction fetch stage and the ALU zero flag. It drives the fetch stage's PC controls (`PC_LdEn`, `PC_Sel`) and every datapath enable and select. It is the decode/sequencing end of the fetch interface: it alone decides when the PC advances and whether a branch is taken.

## Interface
- No parameters.
- `Clk` in 1: sole clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high; forces state FETCH and all registered outputs to 0.
- `Instr` in 32: instruction word from IMEM.
  - Fields: opcode `[31:26]`, func `[3:0]`.
- `Zero` in 1: ALU zero flag, combinational, valid in the same cycle as the ALU inputs.
- `PC_LdEn` out 1: PC load enable to fetch stage.
- `PC_Sel` out 1: 0 = PC+4, 1 = PC+4+`PC_Immed`.
- `IR_LdEn` out 1: instruction register load.
- `RF_WrEn` out 1: register file write.
- `RF_WrData_sel` out 1: 0 = ALU result, 1 = memory data.
- `RF_B_sel` out 1: 0 = rt field, 1 = rd field as RF read port B.
- `ALU_Bin_sel` out 1: 0 = RF B, 1 = extended immediate.
- `ALU_func` out 4: ALU operation.
- `ImmExt` out 2: immediate extension mode.
  - 00 = sign-extend.
  - 01 = zero-fill.
  - 10 = `<<16`.
  - 11 = sign-extend `<<2`.
- `Mem_WrEn` out 1: data memory write.
- `ByteOp` out 1: 1 = byte access.

## Operation
- Opcodes:
  - 100000 R-type.
  - 111000 li.
  - 111001 lui.
  - 110000 addi.
  - 110010 andi.
  - 110011 ori.
  - 111111 b.
  - 000000 beq.
  - 000001 bne.
  - 000011 lb.
  - 000111 sb.
  - 001111 lw.
  - 011111 sw.
- li and lui are encoded with rs = r0 and execute as an add with the immediate.
- States: FETCH, DECODE, EXEC_R, EXEC_I, EXEC_BR, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM.
- FETCH: IMEM read in flight; all outputs 0 → DECODE.
- DECODE: `IR_LdEn`=1; `RF_B_sel`=1 for beq/bne/sw/sb, otherwise 0. Next state by opcode:
  - R-type → EXEC_R.
  - li/lui/addi/andi/ori → EXEC_I.
  - b/beq/bne → EXEC_BR.
  - loads/stores → MEM_ADDR.
- EXEC_R: `ALU_func`=`Instr[3:0]`, `ALU_Bin_sel`=0 → WB_ALU.
- EXEC_I: `ALU_Bin_sel`=1 → WB_ALU.
  - addi, li: `ALU_func` 0000, `ImmExt` 00.
  - lui: `ALU_func` 0000, `ImmExt` 10.
  - andi: `ALU_func` 0010, `ImmExt` 01.
  - ori: `ALU_func` 0011, `ImmExt` 01.
- EXEC_BR: `ALU_func`=0001 (sub), `ALU_Bin_sel`=0, `RF_B_sel`=1, `ImmExt`=11, `PC_LdEn`=1 → FETCH.
  - `PC_Sel`=1 for b, `Zero` for beq, `!Zero` for bne.
- MEM_ADDR: `ALU_func`=0000, `ALU_Bin_sel`=1, `ImmExt`=00 → MEM_RD (loads) or MEM_WR (stores).
- MEM_WR: `Mem_WrEn`=1, `ByteOp`=(opcode==sb), `PC_LdEn`=1, `PC_Sel`=0 → FETCH.
- MEM_RD: `ByteOp`=(opcode==lb); waits one cycle for synchronous memory → WB_MEM.
- WB_ALU / WB_MEM: `RF_WrEn`=1, `RF_WrData_sel`=0 / 1, `PC_LdEn`=1, `PC_Sel`=0 → FETCH.
  - ALU selects from the exec state are held through WB_ALU.
- Undefined opcode: DECODE → FETCH with `PC_LdEn`=1, `PC_Sel`=0 (NOP).
- Outputs are a registered decode of the next state plus the latched opcode. `PC_Sel` is the exception: it is combinational from `Zero` in EXEC_BR.

## Timing
- After `Reset` deasserts, the first cycle is FETCH; all outputs are 0.
- `PC_LdEn` is high for exactly one cycle per instruction, always in that instruction's final state.
- Instruction latency in cycles (FETCH through final state):
  - branch 3.
  - R/I 4.
  - sw/sb 4.
  - lw/lb 5.
  - NOP 2.
- The opcode is latched in DECODE. Changes on `Instr` after DECODE are ignored until the next DECODE.
- `Reset` asserted in any state: next state FETCH, all outputs 0, no write strobe in that cycle. Reset has priority over every transition.
- `PC_LdEn` and `RF_WrEn`/`Mem_WrEn` may coincide; the write uses the current instruction's operands.

## Configuration
- `CTRL_BYTE_OPS_EN` defined: lb/sb are decoded as described; `ByteOp` is driven.
- Not defined: lb/sb are undefined opcodes (NOP path); `ByteOp` is tied to 0; lw/sw are unaffected.

## Test plan
- Reset held 3 cycles, then `Instr`=0x80000000 (R-type add) → FETCH, DECODE, EXEC_R, WB_ALU.
  - `RF_WrEn`=1 and `PC_LdEn`=1 only in cycle 4; `ALU_func`=0000.
- beq with `Zero`=1 → `PC_LdEn`=1, `PC_Sel`=1, `ImmExt`=11 in cycle 3.
  - Same with `Zero`=0 → `PC_Sel`=0.
- lw (0x3C...) → `RF_WrData_sel`=1, `RF_WrEn`=1 in cycle 5; `Mem_WrEn` never 1.
- sb with `CTRL_BYTE_OPS_EN` → `Mem_WrEn`=1, `ByteOp`=1 in cycle 4.
  - Without the macro → NOP: `PC_LdEn`=1 in cycle 2, no write.
- `Reset` pulsed during MEM_RD → next cycle FETCH, `RF_WrEn`=0, all outputs 0.
- Opcode 0x2A (undefined) → `PC_LdEn`=1, `PC_Sel`=0 in cycle 2; `RF_WrEn`=0, `Mem_WrEn`=0.
